// File: rtl/id_ex_register.sv
// ID/EX pipeline register: selects ALU operands and shift amount, detects
// load-use hazards against the instruction in EX, and counts inserted bubbles.
module id_ex_register #(
  parameter int          DATA_W         = 32,
  parameter logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  input  logic [3:0]        alu_op_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              branch_i,
  input  logic [2:0]        funct3_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [4:0]        shamt_o,
  output logic [3:0]        alu_op_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              branch_o,
  output logic              hazard_o,
  output logic              stall_o,
  output logic [15:0]       bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        shamt;
    logic [3:0]        alu_op;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } ex_t;

  ex_t         ex_q, ex_d, load_c;
  logic [15:0] cnt_q, cnt_d;
  logic        rs1_hit, rs2_hit, hazard_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= BUBBLE_CNT_MAX) ? BUBBLE_CNT_MAX : v + 16'd1;
  endfunction

  // A bubble in EX can never be a producer, so a hazard clears itself after one bubble.
  always_comb begin
    rs1_hit  = use_rs1_i && (rs1_i == ex_q.rd);
    rs2_hit  = use_rs2_i && (rs2_i == ex_q.rd);
    hazard_c = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && valid_i &&
               (rs1_hit || rs2_hit);
  end

  always_comb begin
    load_c            = '0;
    load_c.valid      = 1'b1;
    load_c.pc         = pc_i;
    load_c.op_a       = rs1_data_i;
    load_c.op_b       = alu_src_i ? imm_i : rs2_data_i;
    load_c.store_data = rs2_data_i;
    load_c.shamt      = alu_src_i ? imm_i[4:0] : rs2_data_i[4:0];
    load_c.alu_op     = alu_op_i;
    load_c.rd         = rd_i;
    load_c.funct3     = funct3_i;
    load_c.reg_write  = reg_write_i;
    load_c.mem_read   = mem_read_i;
    load_c.mem_write  = mem_write_i;
    load_c.branch     = branch_i;
  end

  // Edge priority: flush, then hold, then hazard bubble, then load.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (hazard_c) begin
      ex_d  = '0;
      cnt_d = sat_inc(cnt_q);
    end else if (!valid_i) begin
      ex_d = '0;
    end else begin
      ex_d = load_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o      = ex_q.valid;
  assign pc_o         = ex_q.pc;
  assign op_a_o       = ex_q.op_a;
  assign op_b_o       = ex_q.op_b;
  assign store_data_o = ex_q.store_data;
  assign shamt_o      = ex_q.shamt;
  assign alu_op_o     = ex_q.alu_op;
  assign rd_o         = ex_q.rd;
  assign funct3_o     = ex_q.funct3;
  assign reg_write_o  = ex_q.reg_write;
  assign mem_read_o   = ex_q.mem_read;
  assign mem_write_o  = ex_q.mem_write;
  assign branch_o     = ex_q.branch;
  assign hazard_o     = hazard_c;
  assign stall_o      = hazard_c | stall_i;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst_n_i, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have stall_i, input, 1, downstream hold; register keeps contents.
REQ-004 SHALL have flush_i, input, 1, squash; next state is a bubble.
REQ-005 SHALL have valid_i, input, 1, decode stage presents a real instruction.
REQ-006 SHALL have pc_i, rs1_data_i, rs2_data_i, imm_i, inputs, 32 each, decoded operands.
REQ-007 SHALL have rs1_i, rs2_i, rd_i, inputs, 5 each, register addresses.
REQ-008 SHALL have use_rs1_i, use_rs2_i, inputs, 1 each, instruction reads rs1/rs2.
REQ-009 SHALL have alu_op_i, input, 4, ALU operation code (codes from defines.v, incl. ALU_SLL/SRL/SRA).
REQ-010 SHALL have alu_src_i, reg_write_i, mem_read_i, mem_write_i, branch_i, inputs, 1 each; funct3_i, input, 3.
REQ-011 SHALL have valid_o, output, 1; pc_o, op_a_o, op_b_o, store_data_o, outputs, 32 each.
REQ-012 SHALL have shamt_o, output, 5, shift amount to shifter; alu_op_o, output, 4; rd_o, output, 5; funct3_o, output, 3.
REQ-013 SHALL have reg_write_o, mem_read_o, mem_write_o, branch_o, outputs, 1 each.
REQ-014 SHALL have hazard_o, output, 1, combinational load-use hazard; stall_o, output, 1, upstream hold request.
REQ-015 SHALL have bubble_cnt_o, output, 16, count of inserted load-use bubbles.

Function
REQ-016 SHALL register op_a_o=rs1_data_i; op_b_o=alu_src_i?imm_i:rs2_data_i; store_data_o=rs2_data_i.
REQ-017 SHALL register shamt_o=alu_src_i?imm_i[4:0]:rs2_data_i[4:0], loaded with same condition as op_b_o.
REQ-018 SHALL pass pc, rd, alu_op, funct3 and control bits through unchanged on a load; latency exactly 1 cycle.
REQ-019 SHALL compute hazard_o = valid_o & mem_read_o & (rd_o!=0) & valid_i & ((use_rs1_i & rs1_i==rd_o) | (use_rs2_i & rs2_i==rd_o)).
REQ-020 SHALL drive stall_o = hazard_o | stall_i, combinationally.
REQ-021 SHALL apply per-edge priority: reset > flush_i > stall_i (hold) > hazard_o (bubble) > load.
REQ-022 SHALL form a bubble as valid_o=0, reg_write_o=mem_read_o=mem_write_o=branch_o=0, rd_o=0, alu_op_o=0; data fields don't-care but zeroed.
REQ-023 SHALL treat valid_i=0 on a load as a bubble (same as REQ-022).
REQ-024 SHALL on flush_i with stall_i also high still bubble (flush wins over hold).
REQ-025 SHALL on stall_i with hazard_o high hold contents and not count a bubble.
REQ-026 SHALL increment bubble_cnt_o only on an edge where the hazard bubble is actually inserted (REQ-021 branch taken); saturate at 16'hFFFF, no wrap.
REQ-027 SHALL not insert a second bubble for the same dependency: after bubble, valid_o=0 so hazard_o drops and instruction loads next cycle.
REQ-028 SHALL never flag hazard for rd_o=0 (x0) or when the EX instruction is not a load.

Reset
REQ-029 SHALL on rst_n_i=0 at a rising edge clear every registered output and bubble_cnt_o to 0, overriding flush/stall.
REQ-030 SHALL, reset asserted mid-stall or mid-bubble, leave no residual state; first edge after release behaves as REQ-021 from empty.

Verification
REQ-031 Load: valid_i=1, alu_op_i=ALU_SLL, alu_src_i=1, imm_i=32'h0000_0023, rs1_data_i=32'h1 -> next cycle valid_o=1, op_a_o=1, shamt_o=5'h03, op_b_o=32'h23.
REQ-032 Register shamt: alu_src_i=0, rs2_data_i=32'hFFFF_FFE7 -> shamt_o=5'h07, op_b_o=32'hFFFF_FFE7.
REQ-033 Load-use: EX holds lw rd=5 (mem_read_o=1); ID valid_i=1, use_rs1_i=1, rs1_i=5 -> hazard_o=1, stall_o=1; next edge valid_o=0, bubble_cnt_o=1; following edge ID instr loaded, hazard_o=0.
REQ-034 x0 / non-load: lw rd=0 with rs1_i=0, or add rd=5 with rs1_i=5 -> hazard_o=0, no bubble, counter unchanged.
REQ-035 Stall vs flush: valid_o=1 held, stall_i=1 for 3 cycles -> outputs frozen; then stall_i=1 & flush_i=1 -> next cycle valid_o=0, reg_write_o=0.
REQ-036 Reset mid-operation: counter at 16'hFFFF saturated, extra hazard -> stays 16'hFFFF; rst_n_i=0 one edge -> all outputs 0, bubble_cnt_o=0.
